// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_if
//  Description : tx/rx word streams and SPI pins of spi_master, grouped.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_if #(
  parameter int DATA_LEN = 8
);
  logic [DATA_LEN-1:0] tx_tdata;
  logic                tx_tvalid;
  logic                tx_tready;
  logic [DATA_LEN-1:0] rx_tdata;
  logic                rx_tvalid;
  logic                rx_tready;
  logic                spi_sclk;
  logic                spi_mosi;
  logic                spi_miso;
  logic                spi_cs_n;

  modport master (
    input  tx_tdata, tx_tvalid, rx_tready, spi_miso,
    output tx_tready, rx_tdata, rx_tvalid, spi_sclk, spi_mosi, spi_cs_n
  );

  modport slave (
    output tx_tdata, tx_tvalid, rx_tready, spi_miso,
    input  tx_tready, rx_tdata, rx_tvalid, spi_sclk, spi_mosi, spi_cs_n
  );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : Single-word SPI master, SCLK idles low, MOSI MSB first,
//                MISO captured on each SCLK falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int DATA_LEN = 8,
  parameter int CS_GAP   = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  localparam int c_PW = $clog2(CLK_DIV + 1);
  localparam int c_BW = $clog2(DATA_LEN + 1);
  localparam int c_GW = $clog2(CS_GAP + 1);

  localparam logic [c_PW-1:0] c_PHASE_LAST = c_PW'(CLK_DIV - 1);
  localparam logic [c_PW-1:0] c_PHASE_ONE  = c_PW'(1);
  localparam logic [c_BW-1:0] c_BIT_LAST   = c_BW'(DATA_LEN);
  localparam logic [c_BW-1:0] c_BIT_ONE    = c_BW'(1);
  localparam logic [c_GW-1:0] c_GAP_LAST   = c_GW'(CS_GAP - 1);
  localparam logic [c_GW-1:0] c_GAP_ONE    = c_GW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t              r_state,     w_state_next;
  logic [c_PW-1:0]     r_phase,     w_phase_next;
  logic [c_BW-1:0]     r_bit_cnt,   w_bit_cnt_next;
  logic [c_GW-1:0]     r_gap_cnt,   w_gap_cnt_next;
  logic [DATA_LEN-1:0] r_tx_shift,  w_tx_shift_next;
  logic [DATA_LEN-1:0] r_rx_shift,  w_rx_shift_next;
  logic [DATA_LEN-1:0] r_rx_tdata,  w_rx_tdata_next;
  logic                r_rx_tvalid, w_rx_tvalid_next;
  logic                r_sclk,      w_sclk_next;
  logic                r_cs_n,      w_cs_n_next;

  logic w_tx_tready;
  logic w_phase_done;

  assign w_tx_tready  = (r_state == IDLE) && !r_rx_tvalid;
  assign w_phase_done = (r_phase == c_PHASE_LAST);

  // MOSI is the top of the tx shift register, so it is registered and
  // already holds the MSB on the cycle after acceptance.
  assign bus.tx_tready = w_tx_tready;
  assign bus.rx_tdata  = r_rx_tdata;
  assign bus.rx_tvalid = r_rx_tvalid;
  assign bus.spi_sclk  = r_sclk;
  assign bus.spi_mosi  = r_tx_shift[DATA_LEN-1];
  assign bus.spi_cs_n  = r_cs_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_tdata  <= '0;
      r_rx_tvalid <= 1'b0;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_tx_shift  <= w_tx_shift_next;
      r_rx_shift  <= w_rx_shift_next;
      r_rx_tdata  <= w_rx_tdata_next;
      r_rx_tvalid <= w_rx_tvalid_next;
      r_sclk      <= w_sclk_next;
      r_cs_n      <= w_cs_n_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_bit_cnt_next   = r_bit_cnt;
    w_gap_cnt_next   = r_gap_cnt;
    w_tx_shift_next  = r_tx_shift;
    w_rx_shift_next  = r_rx_shift;
    w_rx_tdata_next  = r_rx_tdata;
    w_rx_tvalid_next = r_rx_tvalid;
    w_sclk_next      = r_sclk;
    w_cs_n_next      = r_cs_n;

    if (r_rx_tvalid && bus.rx_tready) begin
      w_rx_tvalid_next = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (bus.tx_tvalid && w_tx_tready) begin
          w_state_next    = SETUP;
          w_tx_shift_next = bus.tx_tdata;
          w_cs_n_next     = 1'b0;
          w_sclk_next     = 1'b0;
          w_phase_next    = '0;
          w_bit_cnt_next  = '0;
        end
      end

      SETUP: begin
        if (w_phase_done) begin
          w_phase_next = '0;
          w_sclk_next  = 1'b1;
          w_state_next = SCLK_HI;
        end else begin
          w_phase_next = r_phase + c_PHASE_ONE;
        end
      end

      SCLK_HI: begin
        if (w_phase_done) begin
          w_phase_next    = '0;
          w_sclk_next     = 1'b0;
          w_rx_shift_next = {r_rx_shift[DATA_LEN-2:0], bus.spi_miso};
          w_bit_cnt_next  = r_bit_cnt + c_BIT_ONE;
          w_state_next    = SCLK_LO;
        end else begin
          w_phase_next = r_phase + c_PHASE_ONE;
        end
      end

      // The low phase after the last falling edge runs in full before HOLD.
      SCLK_LO: begin
        if (w_phase_done) begin
          w_phase_next = '0;
          if (r_bit_cnt == c_BIT_LAST) begin
            w_state_next = HOLD;
          end else begin
            w_sclk_next     = 1'b1;
            w_tx_shift_next = {r_tx_shift[DATA_LEN-2:0], 1'b0};
            w_state_next    = SCLK_HI;
          end
        end else begin
          w_phase_next = r_phase + c_PHASE_ONE;
        end
      end

      HOLD: begin
        if (w_phase_done) begin
          w_phase_next     = '0;
          w_cs_n_next      = 1'b1;
          w_rx_tdata_next  = r_rx_shift;
          w_rx_tvalid_next = 1'b1;
          w_gap_cnt_next   = '0;
          w_state_next     = GAP;
        end else begin
          w_phase_next = r_phase + c_PHASE_ONE;
        end
      end

      GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_gap_cnt_next = '0;
          w_state_next   = IDLE;
        end else begin
          w_gap_cnt_next = r_gap_cnt + c_GAP_ONE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master
//  Description : Directed self-checking bench for spi_master (8-bit words).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   miso_tied = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  spi_master_if #(.DATA_LEN(8)) bus ();

  spi_master #(
    .CLK_DIV  (4),
    .DATA_LEN (8),
    .CS_GAP   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.spi_miso = miso_tied ? 1'b1 : bus.spi_mosi;

  // Line monitor, sampled on the falling clk edge.
  int   cyc = 0;
  int   rises, cs_low, min_per, max_per, last_rise, min_gap, cs_rise_cyc;
  bit   mosi_hi, rxv_seen, have_rise;
  logic prev_sclk = 1'b0;
  logic prev_cs   = 1'b1;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (!bus.spi_cs_n) cs_low++;
    if (!bus.spi_cs_n && bus.spi_mosi) mosi_hi = 1'b1;
    if (bus.rx_tvalid) rxv_seen = 1'b1;
    if (bus.rx_tvalid && bus.rx_tready) rx_q.push_back(bus.rx_tdata);
    if (bus.spi_sclk && !prev_sclk) begin
      rises++;
      if (last_rise >= 0) begin
        if (cyc - last_rise < min_per) min_per = cyc - last_rise;
        if (cyc - last_rise > max_per) max_per = cyc - last_rise;
      end
      last_rise = cyc;
    end
    if (bus.spi_cs_n && !prev_cs) begin
      cs_rise_cyc = cyc;
      have_rise   = 1'b1;
    end
    if (!bus.spi_cs_n && prev_cs && have_rise && (cyc - cs_rise_cyc < min_gap))
      min_gap = cyc - cs_rise_cyc;
    prev_sclk = bus.spi_sclk;
    prev_cs   = bus.spi_cs_n;
    cyc++;
  end

  task automatic mon_clear();
    rises = 0; cs_low = 0; min_per = 1000; max_per = 0; last_rise = -1;
    mosi_hi = 1'b0; rxv_seen = 1'b0; min_gap = 1000; have_rise = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present a word and wait for the accepting edge; tx_tvalid is left high.
  task automatic accept_word(input string tag, input logic [7:0] d);
    bit ok = 1'b0;
    bus.tx_tdata  = d;
    bus.tx_tvalid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.tx_tready) ok = 1'b1;
      @(posedge clk); #1;
    end
    check(tag, ok, 1);
  endtask

  task automatic wait_rx(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.rx_tvalid) ok = 1'b1;
    end
    check(tag, ok, 1);
  endtask

  task automatic rx_pulse();
    bus.rx_tready = 1'b1;
    @(posedge clk); #1;
    bus.rx_tready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tr_hi, cs_lo_cnt;
    bit ok;
    logic [7:0] vals [3];
    vals[0] = 8'h81; vals[1] = 8'h7E; vals[2] = 8'h55;

    bus.tx_tdata  = '0;
    bus.tx_tvalid = 1'b0;
    bus.rx_tready = 1'b0;
    mon_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_n",      bus.spi_cs_n,  1);
    check("rst_sclk",      bus.spi_sclk,  0);
    check("rst_mosi",      bus.spi_mosi,  0);
    check("rst_rx_tvalid", bus.rx_tvalid, 0);
    check("rst_rx_tdata",  bus.rx_tdata,  0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_tready", bus.tx_tready, 1);

    // 0xA5 looped back
    mon_clear();
    accept_word("a_accept", 8'hA5);
    bus.tx_tvalid = 1'b0;
    wait_rx("a_rx");
    check("a_rx_tdata", bus.rx_tdata, 8'hA5);
    check("a_rises",    rises,        8);
    check("a_min_per",  min_per,      8);
    check("a_max_per",  max_per,      8);
    check("a_cs_low",   cs_low,       72);
    check("a_tready_rxpend", bus.tx_tready, 0);
    repeat (10) @(posedge clk);
    #1;
    check("a_rx_hold_valid", bus.rx_tvalid, 1);
    check("a_rx_hold_data",  bus.rx_tdata,  8'hA5);
    rx_pulse();
    check("a_rx_clear",   bus.rx_tvalid, 0);
    check("a_tready_back", bus.tx_tready, 1);

    // MISO tied high, tx 0x00
    miso_tied = 1'b1;
    mon_clear();
    accept_word("b_accept", 8'h00);
    bus.tx_tvalid = 1'b0;
    wait_rx("b_rx");
    check("b_rx_tdata", bus.rx_tdata, 8'hFF);
    check("b_mosi_hi",  mosi_hi,      0);
    rx_pulse();
    miso_tied = 1'b0;

    // Back-pressure: second word waits for the rx handshake
    mon_clear();
    accept_word("c_accept", 8'h3C);
    bus.tx_tdata = 8'hC3;
    wait_rx("c_rx1");
    check("c_rx1_tdata", bus.rx_tdata, 8'h3C);
    tr_hi = 0; cs_lo_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.tx_tready) tr_hi++;
      if (!bus.spi_cs_n) cs_lo_cnt++;
    end
    check("c_tready_blocked", tr_hi,     0);
    check("c_no_cs",          cs_lo_cnt, 0);
    check("c_rx1_held",       bus.rx_tdata, 8'h3C);
    rx_pulse();
    check("c_rx_clear",      bus.rx_tvalid, 0);
    check("c_not_yet_taken", bus.spi_cs_n,  1);
    @(posedge clk); #1;
    check("c_taken_next", bus.spi_cs_n, 0);
    bus.tx_tvalid = 1'b0;
    wait_rx("c_rx2");
    check("c_rx2_tdata", bus.rx_tdata, 8'hC3);
    rx_pulse();

    // Streaming with rx_tready held high
    rx_q.delete();
    mon_clear();
    bus.rx_tready = 1'b1;
    for (int w = 0; w < 3; w++) accept_word("d_accept", vals[w]);
    bus.tx_tvalid = 1'b0;
    for (int i = 0; i < 600 && rx_q.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    check("d_count", rx_q.size(), 3);
    for (int w = 0; w < 3 && w < rx_q.size(); w++) check("d_word", rx_q[w], vals[w]);
    check("d_gap_ge_2", (min_gap >= 2 && min_gap < 1000), 1);
    bus.rx_tready = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-word, then a clean word
    mon_clear();
    accept_word("e_accept", 8'hA5);
    bus.tx_tvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (rises >= 4) ok = 1'b1;
    end
    check("e_reach_rise4", ok, 1);
    #2;
    rst = 1'b1;
    #1;
    check("e_rst_cs_n", bus.spi_cs_n, 1);
    check("e_rst_sclk", bus.spi_sclk, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("e_tready", bus.tx_tready, 1);
    repeat (20) @(posedge clk);
    #1;
    check("e_no_rxvalid", rxv_seen, 0);
    mon_clear();
    accept_word("e2_accept", 8'h5A);
    bus.tx_tvalid = 1'b0;
    wait_rx("e2_rx");
    check("e2_rx_tdata", bus.rx_tdata, 8'h5A);
    check("e2_rises",    rises,        8);
    check("e2_cs_low",   cs_low,       72);
    rx_pulse();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
